// File: rtl/mips_multicycle_ctrl_if.sv
// Control/datapath bundle for the multicycle MIPS controller: instruction fields and
// flags in, mux selects, strobes and debug status out.
interface mips_multicycle_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       Opcode;
    logic [5:0]       Funct;
    logic             Zero;
    logic             mem_ready;
    logic             PCWrite;
    logic             PCWriteCond;
    logic             IorD;
    logic             MemRead;
    logic             MemWrite;
    logic             IRWrite;
    logic             MemtoReg;
    logic             RegDst;
    logic             RegWrite;
    logic             ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic [2:0]       ALUControl;
    logic [1:0]       PCSrc;
    logic             Fault;
    logic [3:0]       State;
    logic [CNT_W-1:0] instr_count;

    // The controller is the master: it consumes instruction fields and drives the datapath.
    modport master (
        input  Opcode, Funct, Zero, mem_ready,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
               RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUControl, PCSrc, Fault,
               State, instr_count
    );

    modport slave (
        output Opcode, Funct, Zero, mem_ready,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
               RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUControl, PCSrc, Fault,
               State, instr_count
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS32 control FSM with a mem_ready handshake and a saturating retire counter.
// Optional MCTRL_MEM_TIMEOUT_EN halts the core after MEM_TIMEOUT unanswered memory wait cycles.
module mips_multicycle_ctrl #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 15
) (
    input logic                clock,
    input logic                Reset,
    mips_multicycle_ctrl_if.master bus
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef enum logic [3:0] {
        S_RST    = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_JUMP   = 4'd12,
        S_HALT   = 4'd13
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] count;
    logic             legal_funct;
    logic             retire;
    logic             timeout;

    if (MEM_TIMEOUT < 1) begin : g_bad_timeout
        $error("MEM_TIMEOUT must be at least 1");
    end

    assign legal_funct = (bus.Funct == FN_ADD) || (bus.Funct == FN_SUB) ||
                         (bus.Funct == FN_AND) || (bus.Funct == FN_OR)  ||
                         (bus.Funct == FN_SLT);

`ifdef MCTRL_MEM_TIMEOUT_EN
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    logic              mem_wait;
    logic [WAIT_W-1:0] wait_cnt;

    assign mem_wait = ((state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR)) &&
                      !bus.mem_ready;

    // Any state change restarts the count, so each wait state begins at zero.
    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset)
            wait_cnt <= '0;
        else if (next_state != state)
            wait_cnt <= '0;
        else if (mem_wait)
            wait_cnt <= wait_cnt + WAIT_W'(1);
    end

    assign timeout = mem_wait && (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset)
            state <= S_RST;
        else
            state <= next_state;
    end

    // A completed access always wins over a timeout landing on the same cycle.
    always_comb begin
        next_state = state;
        case (state)
            S_RST:    next_state = S_FETCH;
            S_FETCH:  if (bus.mem_ready) next_state = S_DECODE;
                      else if (timeout)  next_state = S_HALT;
            S_DECODE: begin
                case (bus.Opcode)
                    OP_LW, OP_SW:   next_state = S_MEMADR;
                    OP_RTYPE:       next_state = legal_funct ? S_EXEC : S_HALT;
                    OP_BEQ, OP_BNE: next_state = S_BRANCH;
                    OP_ADDI:        next_state = S_ADDIEX;
                    OP_J:           next_state = S_JUMP;
                    default:        next_state = S_HALT;
                endcase
            end
            S_MEMADR: next_state = (bus.Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (bus.mem_ready) next_state = S_MEMWB;
                      else if (timeout)  next_state = S_HALT;
            S_MEMWB:  next_state = S_FETCH;
            S_MEMWR:  if (bus.mem_ready) next_state = S_FETCH;
                      else if (timeout)  next_state = S_HALT;
            S_EXEC:   next_state = S_ALUWB;
            S_ALUWB:  next_state = S_FETCH;
            S_BRANCH: next_state = S_FETCH;
            S_ADDIEX: next_state = S_ADDIWB;
            S_ADDIWB: next_state = S_FETCH;
            S_JUMP:   next_state = S_FETCH;
            S_HALT:   next_state = S_HALT;
            default:  next_state = S_HALT;
        endcase
    end

    always_comb begin
        bus.PCWrite     = 1'b0;
        bus.PCWriteCond = 1'b0;
        bus.IorD        = 1'b0;
        bus.MemRead     = 1'b0;
        bus.MemWrite    = 1'b0;
        bus.IRWrite     = 1'b0;
        bus.MemtoReg    = 1'b0;
        bus.RegDst      = 1'b0;
        bus.RegWrite    = 1'b0;
        bus.ALUSrcA     = 1'b0;
        bus.ALUSrcB     = 2'b00;
        bus.ALUControl  = 3'b000;
        bus.PCSrc       = 2'b00;
        bus.Fault       = 1'b0;
        case (state)
            S_FETCH: begin
                bus.MemRead    = 1'b1;
                bus.ALUSrcB    = 2'b01;
                bus.ALUControl = 3'b010;
                bus.IRWrite    = bus.mem_ready;
                bus.PCWrite    = bus.mem_ready;
            end
            S_DECODE: begin
                bus.ALUSrcB    = 2'b11;
                bus.ALUControl = 3'b010;
            end
            S_MEMADR, S_ADDIEX: begin
                bus.ALUSrcA    = 1'b1;
                bus.ALUSrcB    = 2'b10;
                bus.ALUControl = 3'b010;
            end
            S_MEMRD: begin
                bus.MemRead = 1'b1;
                bus.IorD    = 1'b1;
            end
            S_MEMWB: begin
                bus.RegWrite = 1'b1;
                bus.MemtoReg = 1'b1;
            end
            S_MEMWR: begin
                bus.MemWrite = 1'b1;
                bus.IorD     = 1'b1;
            end
            S_EXEC: begin
                bus.ALUSrcA = 1'b1;
                case (bus.Funct)
                    FN_ADD:  bus.ALUControl = 3'b010;
                    FN_SUB:  bus.ALUControl = 3'b110;
                    FN_AND:  bus.ALUControl = 3'b000;
                    FN_OR:   bus.ALUControl = 3'b001;
                    FN_SLT:  bus.ALUControl = 3'b111;
                    default: bus.ALUControl = 3'b000;
                endcase
            end
            S_ALUWB: begin
                bus.RegWrite = 1'b1;
                bus.RegDst   = 1'b1;
            end
            S_BRANCH: begin
                bus.ALUSrcA     = 1'b1;
                bus.ALUControl  = 3'b110;
                bus.PCSrc       = 2'b01;
                bus.PCWriteCond = (bus.Opcode == OP_BNE) ? !bus.Zero : bus.Zero;
            end
            S_ADDIWB: bus.RegWrite = 1'b1;
            S_JUMP: begin
                bus.PCWrite = 1'b1;
                bus.PCSrc   = 2'b10;
            end
            S_HALT:   bus.Fault = 1'b1;
            default:  bus.Fault = 1'b0;
        endcase
    end

    // Only the final step of a real instruction retires it; RST -> FETCH does not count.
    assign retire = (next_state == S_FETCH) &&
                    (state inside {S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP});

    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset)
            count <= '0;
        else if (retire && (count != {CNT_W{1'b1}}))
            count <= count + CNT_W'(1);
    end

    assign bus.State       = state;
    assign bus.instr_count = count;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Randomized self-checking bench for mips_multicycle_ctrl against an instruction-level model.
// Build with MCTRL_MEM_TIMEOUT_EN defined to exercise the memory timeout path.
module tb_mips_multicycle_ctrl;

    localparam int CNT_W       = 3;
    localparam int MEM_TIMEOUT = 4;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    logic clock = 1'b0;
    logic Reset = 1'b0;
    int   passCount  = 0;
    int   checkCount = 0;
    int   modelCount = 0;
    bit   halted;

    logic [5:0] legalFunct [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    logic [2:0] legalAlu   [5] = '{3'b010,    3'b110,    3'b000,    3'b001,    3'b111};

    always #5 clock = ~clock;

    mips_multicycle_ctrl_if #(.CNT_W(CNT_W)) bus ();

    mips_multicycle_ctrl #(
        .CNT_W      (CNT_W),
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) dut (
        .clock(clock),
        .Reset(Reset),
        .bus  (bus.master)
    );

    function automatic logic [17:0] obsVec();
        return {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite,
                bus.MemtoReg, bus.RegDst, bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB,
                bus.ALUControl, bus.PCSrc, bus.Fault};
    endfunction

    function automatic int functIndex(input logic [5:0] fn);
        for (int i = 0; i < 5; i++)
            if (legalFunct[i] == fn) return i;
        return -1;
    endfunction

    // Expected control word for one cycle, read straight off the per-state output table.
    function automatic logic [17:0] expVec(input int st, input logic [5:0] op, input logic [5:0] fn,
                                           input logic z, input logic mr);
        logic       pcw = 1'b0, pcwc = 1'b0, iord = 1'b0, mrd = 1'b0, mwr = 1'b0, irw = 1'b0;
        logic       m2r = 1'b0, rdst = 1'b0, rw = 1'b0, srca = 1'b0, flt = 1'b0;
        logic [1:0] srcb = 2'b00, pcs = 2'b00;
        logic [2:0] alu = 3'b000;
        int         fi;
        case (st)
            1:  begin mrd = 1'b1; srcb = 2'b01; alu = 3'b010; irw = mr; pcw = mr; end
            2:  begin srcb = 2'b11; alu = 3'b010; end
            3, 10: begin srca = 1'b1; srcb = 2'b10; alu = 3'b010; end
            4:  begin mrd = 1'b1; iord = 1'b1; end
            5:  begin rw = 1'b1; m2r = 1'b1; end
            6:  begin mwr = 1'b1; iord = 1'b1; end
            7:  begin
                    srca = 1'b1;
                    fi = functIndex(fn);
                    if (fi >= 0) alu = legalAlu[fi];
                end
            8:  begin rw = 1'b1; rdst = 1'b1; end
            9:  begin srca = 1'b1; alu = 3'b110; pcs = 2'b01; pcwc = (op == OP_BNE) ? !z : z; end
            11: rw = 1'b1;
            12: begin pcw = 1'b1; pcs = 2'b10; end
            13: flt = 1'b1;
            default: ;
        endcase
        return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, srcb, alu, pcs, flt};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    endtask

    task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn, input logic z,
                                 input logic mr);
        @(negedge clock);
        bus.Opcode    = op;
        bus.Funct     = fn;
        bus.Zero      = z;
        bus.mem_ready = mr;
    endtask

    task automatic stepCycle(input int st, input logic [5:0] op, input logic [5:0] fn,
                             input logic z, input logic mr, input bit chkCnt);
        applyStimulus(op, fn, z, mr);
        #1;
        checkOutput($sformatf("state_s%0d", st), 32'(bus.State), 32'(st));
        checkOutput($sformatf("outputs_s%0d", st), 32'(obsVec()), 32'(expVec(st, op, fn, z, mr)));
        if (chkCnt) checkOutput("instr_count", 32'(bus.instr_count), 32'(modelCount));
        @(posedge clock);
    endtask

    // Hold reset for n cycles (aborting whatever is running), then release into FETCH.
    task automatic doReset(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(6'($urandom), 6'($urandom), 1'($urandom), 1'b1);
            Reset = 1'b0;
            #1;
            checkOutput("reset_state", 32'(bus.State), 32'd0);
            checkOutput("reset_outputs", 32'(obsVec()), 32'd0);
            checkOutput("reset_count", 32'(bus.instr_count), 32'd0);
        end
        Reset = 1'b1;
        modelCount = 0;
        @(posedge clock);
    endtask

    task automatic runInstr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                            input int stallF, input int stallM, output bit hit);
        int path[$];
        for (int i = 0; i <= stallF; i++)
            stepCycle(1, op, fn, z, (i == stallF), (i == 0));
        case (op)
            OP_LW:          path = {2, 3, 4, 5};
            OP_SW:          path = {2, 3, 6};
            OP_RTYPE:       path = (functIndex(fn) >= 0) ? {2, 7, 8} : {2, 13};
            OP_BEQ, OP_BNE: path = {2, 9};
            OP_ADDI:        path = {2, 10, 11};
            OP_J:           path = {2, 12};
            default:        path = {2, 13};
        endcase
        hit = 1'b0;
        foreach (path[k]) begin
            if (path[k] == 4 || path[k] == 6) begin
                for (int i = 0; i <= stallM; i++)
                    stepCycle(path[k], op, fn, z, (i == stallM), 1'b0);
            end else if (path[k] == 13) begin
                for (int i = 0; i < 10; i++)
                    stepCycle(13, op, fn, z, 1'($urandom), 1'b0);
                hit = 1'b1;
            end else begin
                stepCycle(path[k], op, fn, z, 1'($urandom), 1'b0);
            end
        end
        if (!hit && modelCount < CNT_MAX) modelCount++;
    endtask

    initial begin
        bus.Opcode    = '0;
        bus.Funct     = '0;
        bus.Zero      = 1'b0;
        bus.mem_ready = 1'b0;
        doReset(3);

        runInstr(OP_LW, 6'b000000, 1'b0, 0, 0, halted);
        runInstr(OP_RTYPE, 6'b100010, 1'b0, 0, 0, halted);
        runInstr(OP_SW, 6'b000000, 1'b0, 0, 3, halted);
        runInstr(OP_BNE, 6'b000000, 1'b1, 1, 0, halted);
        runInstr(OP_BNE, 6'b000000, 1'b0, 0, 0, halted);
        runInstr(OP_BEQ, 6'b000000, 1'b1, 2, 0, halted);
        runInstr(OP_ADDI, 6'b000000, 1'b0, 0, 0, halted);
        runInstr(OP_J, 6'b000000, 1'b0, 0, 0, halted);
        runInstr(6'b111111, 6'b000000, 1'b0, 0, 0, halted);
        doReset(2);
        runInstr(OP_RTYPE, 6'b000111, 1'b0, 0, 0, halted);
        doReset(1);

`ifdef MCTRL_MEM_TIMEOUT_EN
        for (int i = 0; i < MEM_TIMEOUT; i++)
            stepCycle(1, OP_J, 6'b000000, 1'b0, 1'b0, (i == 0));
        for (int i = 0; i < 3; i++)
            stepCycle(13, OP_J, 6'b000000, 1'b0, 1'($urandom), 1'b0);
        doReset(1);
        runInstr(OP_J, 6'b000000, 1'b0, MEM_TIMEOUT - 1, 0, halted);
        runInstr(OP_LW, 6'b000000, 1'b0, 0, MEM_TIMEOUT - 1, halted);
`else
        runInstr(OP_J, 6'b000000, 1'b0, 20, 0, halted);
        runInstr(OP_LW, 6'b000000, 1'b0, 0, 20, halted);
`endif

        // Abort a store while it is waiting on memory; nothing may be written after reset.
        stepCycle(1, OP_SW, 6'b000000, 1'b0, 1'b1, 1'b1);
        stepCycle(2, OP_SW, 6'b000000, 1'b0, 1'b1, 1'b0);
        stepCycle(3, OP_SW, 6'b000000, 1'b0, 1'b1, 1'b0);
        stepCycle(6, OP_SW, 6'b000000, 1'b0, 1'b0, 1'b0);
        doReset(2);

        for (int n = 0; n < 40; n++) begin
            logic [5:0] op;
            logic [5:0] fn;
            int         pick;
            pick = $urandom_range(0, 9);
            fn   = legalFunct[$urandom_range(0, 4)];
            case (pick)
                0, 8:    op = OP_LW;
                1:       op = OP_SW;
                2, 7:    op = OP_RTYPE;
                3:       op = OP_BEQ;
                4:       op = OP_BNE;
                5:       op = OP_ADDI;
                6:       op = OP_J;
                default: op = ($urandom_range(0, 1) == 0) ? 6'b001100 : 6'b111111;
            endcase
            if (op == OP_RTYPE && $urandom_range(0, 7) == 0) fn = 6'b000000;
            runInstr(op, fn, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), halted);
            if (halted) doReset(1);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
